// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Holds the FSM state encoding and the default operand width.
package serial_sub_pkg;

  // Default operand/result width; legal range for the controller is 2..32.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states with fixed encodings so debug dumps stay readable.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_ctrl_fs_cell.sv
// One-bit full subtractor: d = x - y - bi (mod 2), bo = borrow out.
// Purely combinational; the controller time-multiplexes a single instance.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic w_xy;

  // Difference and borrow of one bit position.
  always_comb begin
    w_xy = x ^ y;
    d    = w_xy ^ bi;
    bo   = (~x & y) | (~w_xy & bi);
  end

endmodule : fs_cell

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes a - b - bin over WIDTH cycles,
// LSB first, using one fs_cell. Valid/ready on both input and output.
// Optional build macro SUB_OVF_EN adds a registered signed-overflow output ovf.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH  // legal range 2..32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_brw;
  logic             r_bout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_cell_d;
  logic             w_cell_bo;
  logic [WIDTH-1:0] w_res_next;

`ifdef SUB_OVF_EN
  // Operand sign bits, kept aside because the shift registers lose them.
  logic [1:0]       r_msb_ab;
  logic             r_ovf;
`endif

  // The single subtractor cell always looks at the current LSBs and borrow.
  fs_cell u_cell (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .bi (r_brw),
    .d  (w_cell_d),
    .bo (w_cell_bo)
  );

  // Result shift register after this edge's bit enters at the MSB.
  always_comb begin
    w_res_next = {w_cell_d, r_res[WIDTH-1:1]};
  end

  // Controller FSM: operand capture, serial shifting, result hold.
  // NOTE: every state/datapath register uses <= so all of them update together
  // from pre-edge values; a blocking = here would let later lines see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift registers are ordinary flops, not a memory array, so they
      // are reset too; a mid-operation reset must leave no stale partial result.
      r_state     <= S_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_res       <= '0;
      r_diff      <= '0;
      r_brw       <= 1'b0;
      r_bout      <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SUB_OVF_EN
      r_msb_ab    <= 2'b00;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a_sr     <= a;
            r_b_sr     <= b;
            r_brw      <= bin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_SHIFT;
`ifdef SUB_OVF_EN
            r_msb_ab   <= {a[WIDTH-1], b[WIDTH-1]};
`endif
          end
        end

        S_SHIFT: begin
          r_res  <= w_res_next;
          r_a_sr <= r_a_sr >> 1;
          r_b_sr <= r_b_sr >> 1;
          r_brw  <= w_cell_bo;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            // Final bit: publish the completed result in the same edge.
            r_diff      <= w_res_next;
            r_bout      <= w_cell_bo;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef SUB_OVF_EN
            r_ovf       <= (r_msb_ab[1] ^ r_msb_ab[0]) & (r_msb_ab[1] ^ w_cell_d);
`endif
          end
        end

        S_DONE: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
`ifdef SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule : serial_sub_ctrl

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8): directed cases plus
// 1000 random operations, scoreboard-checked against an arithmetic model.
module tb_serial_sub_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;   // {borrow, difference}
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_pushed  = 0;
  int   n_flushed = 0;
  int   n_results = 0;
  bit   rdy_rand  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain unsigned arithmetic on a width-extended value.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
    exp_t e;
    e.res = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    e.ovf = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ e.res[W-1]);
    return e;
  endfunction

  // Monitor: a handshake visible at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_results++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got {bout,diff}=0x%0h with empty scoreboard at %0t",
                 {bout, diff}, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {bout, diff}, e.res);
`ifdef SUB_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
      end
    end
  end

  // Random back-pressure generator, active only during the random phase.
  always begin
    @(posedge clk);
    if (rdy_rand) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present operands until accepted; returns one tick after the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    a        = ia;
    b        = ib;
    bin      = ibin;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin
        sb.push_back(model(ia, ib, ibin));
        n_pushed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    $display("FAIL issue_timeout: in_ready stayed 0 for 300 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Watchdog so a wedged DUT still terminates the run.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int     k;
    exp_t   e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;

    #12;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff",      diff,      0);
    check("rst_bout",      bout,      0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic op with latency and return-to-idle timing.
    issue(8'h5A, 8'h3C, 1'b0);
    wait_valid(k);
    check("latency", k, W);
    @(posedge clk); #1;
    check("idle_in_ready",  in_ready,  1);
    check("idle_out_valid", out_valid, 0);

    // Borrow wrap and borrow-in consumption.
    issue(8'h00, 8'h01, 1'b0);
    issue(8'h10, 8'h0F, 1'b1);
    wait_drain();

    // Back-pressure: result frozen, input side closed.
    out_ready = 1'b0;
    e = model(8'hC3, 8'h5E, 1'b1);
    issue(8'hC3, 8'h5E, 1'b1);
    wait_valid(k);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_diff",      diff,      e.res[W-1:0]);
      check("bp_bout",      bout,      e.res[W]);
      check("bp_in_ready",  in_ready,  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready",  in_ready,  1);
    check("bp_release_out_valid", out_valid, 0);

    // Asynchronous reset in the middle of a shift sequence.
    issue(8'hFF, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready",  in_ready,  1);
    check("arst_out_valid", out_valid, 0);
    check("arst_diff",      diff,      0);
    check("arst_bout",      bout,      0);
    n_flushed += sb.size();
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h03, 8'h05, 1'b0);
    wait_drain();

    // Signed-overflow corner operands (ovf checked when the port exists).
    issue(8'h80, 8'h01, 1'b0);
    issue(8'h7F, 8'hFF, 1'b0);
    issue(8'h05, 8'h03, 1'b0);
    wait_drain();

    // Random traffic with random gaps and random back-pressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end
    wait_drain();
    rdy_rand  = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("result_count", n_results, n_pushed - n_flushed);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_sub_ctrl
